// File: rtl/neander_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neander_pkg: opcodes, ULA select codes, FSM states and opcode classes. Rev 1.0
// ----------------------------------------------------------------------------
package neander_pkg;

  localparam int OP_W  = 4;
  localparam int ULA_W = 3;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_STA = 4'h1;
  localparam logic [OP_W-1:0] OP_LDA = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD = 4'h3;
  localparam logic [OP_W-1:0] OP_OR  = 4'h4;
  localparam logic [OP_W-1:0] OP_AND = 4'h5;
  localparam logic [OP_W-1:0] OP_NOT = 4'h6;
  localparam logic [OP_W-1:0] OP_JMP = 4'h8;
  localparam logic [OP_W-1:0] OP_JN  = 4'h9;
  localparam logic [OP_W-1:0] OP_JZ  = 4'hA;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam logic [ULA_W-1:0] ULA_ADD   = 3'd0;
  localparam logic [ULA_W-1:0] ULA_AND   = 3'd1;
  localparam logic [ULA_W-1:0] ULA_OR    = 3'd2;
  localparam logic [ULA_W-1:0] ULA_NOT   = 3'd3;
  localparam logic [ULA_W-1:0] ULA_PASSY = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_MEM  = 2'd1,
    CLS_JUMP = 2'd2,
    CLS_ALU  = 2'd3
  } op_class_t;

  // Undefined opcodes fall into CLS_NONE and therefore behave as NOP.
  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    case (op)
      OP_NOP:                              op_class = CLS_NONE;
      OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND: op_class = CLS_MEM;
      OP_JMP, OP_JN, OP_JZ:                op_class = CLS_JUMP;
      OP_NOT:                              op_class = CLS_ALU;
      default:                             op_class = CLS_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/neander_opdec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neander_opdec: combinational opcode class decoder and T7 ULA select. Rev 1.0
// ----------------------------------------------------------------------------
module neander_opdec
  import neander_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  input  logic             n_flag,
  input  logic             z_flag,
  output logic             is_mem,
  output logic             is_jump,
  output logic             is_alu,
  output logic             is_sta,
  output logic             is_hlt,
  output logic             skip,
  output logic [ULA_W-1:0] sel_t7
);

  op_class_t w_cls;

  assign w_cls   = op_class(opcode);
  assign is_mem  = (w_cls == CLS_MEM);
  assign is_jump = (w_cls == CLS_JUMP);
  assign is_alu  = (w_cls == CLS_ALU);
  assign is_sta  = (opcode == OP_STA);
  assign is_hlt  = (opcode == OP_HLT);
  // Conditional jump whose condition is false: only the operand byte is skipped.
  assign skip    = ((opcode == OP_JN) && !n_flag) || ((opcode == OP_JZ) && !z_flag);

  always_comb begin
    sel_t7 = ULA_PASSY;
    case (opcode)
      OP_LDA:  sel_t7 = ULA_PASSY;
      OP_ADD:  sel_t7 = ULA_ADD;
      OP_OR:   sel_t7 = ULA_OR;
      OP_AND:  sel_t7 = ULA_AND;
      default: sel_t7 = ULA_PASSY;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/neander_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neander_ctrl: Neander fetch/decode/execute control FSM. Rev 1.0
// Optional NEANDER_SINGLE_STEP_EN: a step pulse in IDLE runs one instruction.
// ----------------------------------------------------------------------------
module neander_ctrl
  import neander_pkg::*;
(
  input  logic             ck,
  input  logic             nReset,
  input  logic             run,
  input  logic             step,
  input  logic [OP_W-1:0]  opcode,
  input  logic             N,
  input  logic             Z,
  input  logic             memRdy,
  output logic             cargaREM,
  output logic             selREM,
  output logic             read,
  output logic             write,
  output logic             incPC,
  output logic             cargaPC,
  output logic             cargaRI,
  output logic             cargaAC,
  output logic             cargaNZ,
  output logic [ULA_W-1:0] selULA,
  output logic             halted
);

  state_t           r_state;
  state_t           w_next;
  logic             w_end;
  logic             w_one_shot;
  logic             w_step_go;
  logic             w_is_mem;
  logic             w_is_jump;
  logic             w_is_alu;
  logic             w_is_sta;
  logic             w_is_hlt;
  logic             w_skip;
  logic [ULA_W-1:0] w_sel_t7;

  neander_opdec u_opdec (
    .opcode  (opcode),
    .n_flag  (N),
    .z_flag  (Z),
    .is_mem  (w_is_mem),
    .is_jump (w_is_jump),
    .is_alu  (w_is_alu),
    .is_sta  (w_is_sta),
    .is_hlt  (w_is_hlt),
    .skip    (w_skip),
    .sel_t7  (w_sel_t7)
  );

`ifdef NEANDER_SINGLE_STEP_EN
  logic r_single;

  assign w_step_go  = (r_state == S_IDLE) && !run && step;
  assign w_one_shot = r_single;

  // Remembers that the instruction in flight was launched by step.
  always_ff @(posedge ck or negedge nReset) begin
    if (!nReset) begin
      r_single <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_single <= w_step_go;
    end
  end
`else
  logic unused_step;

  assign unused_step = step;
  assign w_step_go   = 1'b0;
  assign w_one_shot  = 1'b0;
`endif

  always_ff @(posedge ck or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_end    = 1'b0;
    cargaREM = 1'b0;
    selREM   = 1'b0;
    read     = 1'b0;
    write    = 1'b0;
    incPC    = 1'b0;
    cargaPC  = 1'b0;
    cargaRI  = 1'b0;
    cargaAC  = 1'b0;
    cargaNZ  = 1'b0;
    selULA   = '0;
    halted   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run || w_step_go) w_next = S_T0;
      end
      S_T0: begin
        cargaREM = 1'b1;
        w_next   = S_T1;
      end
      S_T1: begin
        read = 1'b1;
        if (memRdy) begin
          incPC  = 1'b1;
          w_next = S_T2;
        end
      end
      S_T2: begin
        cargaRI = 1'b1;
        w_next  = S_T3;
      end
      S_T3: begin
        if (w_is_hlt) begin
          w_next = S_HALT;
        end else if (w_is_alu) begin
          cargaAC = 1'b1;
          cargaNZ = 1'b1;
          selULA  = ULA_NOT;
          w_end   = 1'b1;
        end else if (w_is_jump && w_skip) begin
          incPC = 1'b1;
          w_end = 1'b1;
        end else if (w_is_mem || w_is_jump) begin
          cargaREM = 1'b1;
          w_next   = S_T4;
        end else begin
          w_end = 1'b1;
        end
      end
      S_T4: begin
        read = 1'b1;
        if (memRdy) begin
          incPC  = w_is_mem;
          w_next = S_T5;
        end
      end
      S_T5: begin
        if (w_is_jump) begin
          cargaPC = 1'b1;
          w_end   = 1'b1;
        end else begin
          cargaREM = 1'b1;
          selREM   = 1'b1;
          w_next   = S_T6;
        end
      end
      S_T6: begin
        write = w_is_sta;
        read  = !w_is_sta;
        if (memRdy) begin
          if (w_is_sta) w_end = 1'b1;
          else          w_next = S_T7;
        end
      end
      S_T7: begin
        cargaAC = 1'b1;
        cargaNZ = 1'b1;
        selULA  = w_sel_t7;
        w_end   = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_end) w_next = (run && !w_one_shot) ? S_T0 : S_IDLE;
  end

endmodule
`default_nettype wire

// File: tb/tb_neander_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_neander_ctrl: drives neander_ctrl with a small datapath/memory model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_neander_ctrl;

  logic       ck = 1'b0;
  logic       nReset, run, step, memRdy;
  logic       nf, zf;
  logic [3:0] opcode;
  logic       cargaREM, selREM, read, write, incPC, cargaPC, cargaRI, cargaAC, cargaNZ, halted;
  logic [2:0] selULA;
  logic [12:0] all_out;

  logic [7:0] mem [256];
  logic [7:0] rm  [256];
  logic [7:0] pc, rem_r, rdm, ri, ac;
  logic [3:0] ops [12];
  int         lats [48];
  int         lat_q [$];
  bit         in_acc;
  int         wait_left;
  int         c_inc, c_ac, c_wr, c_pc, c_read, c_viol, c_not, c_active;
  int         errors = 0;
  int         checks = 0;

  assign opcode  = ri[7:4];
  assign all_out = {cargaREM, selREM, read, write, incPC, cargaPC, cargaRI,
                    cargaAC, cargaNZ, selULA, halted};

  always #5 ck = ~ck;

  neander_ctrl dut (
    .ck(ck), .nReset(nReset), .run(run), .step(step), .opcode(opcode),
    .N(nf), .Z(zf), .memRdy(memRdy),
    .cargaREM(cargaREM), .selREM(selREM), .read(read), .write(write),
    .incPC(incPC), .cargaPC(cargaPC), .cargaRI(cargaRI), .cargaAC(cargaAC),
    .cargaNZ(cargaNZ), .selULA(selULA), .halted(halted)
  );

  typedef struct {
    logic [3:0] op;
    logic       n;
    logic       z;
    logic [7:0] opnd;
    int         cyc;
    int         inc;
    int         nac;
    int         nwr;
    int         npc;
    logic [7:0] ac;
    logic [7:0] m80;
    logic [7:0] pcf;
  } vec_t;

  vec_t tv [16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic reset_env();
    pc = 8'h00; rem_r = 8'h00; rdm = 8'h00; ri = 8'h00; ac = 8'h00;
    nf = 1'b0; zf = 1'b0; in_acc = 1'b0; wait_left = 0;
    c_inc = 0; c_ac = 0; c_wr = 0; c_pc = 0; c_read = 0; c_viol = 0; c_not = 0; c_active = 0;
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
  endtask

  task automatic do_reset();
    nReset = 1'b0; run = 1'b0; step = 1'b0; memRdy = 1'b0;
    @(negedge ck);
    reset_env();
    lat_q.delete();
    @(negedge ck);
    nReset = 1'b1;
  endtask

  // One clock of memory + datapath around the controller; entered at a negedge.
  task automatic one_cycle(output bit h);
    logic s_crem, s_srem, s_rd, s_wr, s_inc, s_cpc, s_cri, s_cac, s_cnz, s_h;
    logic [2:0] s_sel;
    logic [7:0] u, n_pc, n_rem, n_rdm, n_ri, n_ac;
    if ((read || write) && !in_acc) begin
      in_acc    = 1'b1;
      wait_left = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
    end
    memRdy = in_acc && (wait_left == 0);
    if (in_acc && wait_left > 0) wait_left--;
    #1;
    s_crem = cargaREM; s_srem = selREM; s_rd = read; s_wr = write; s_inc = incPC;
    s_cpc = cargaPC; s_cri = cargaRI; s_cac = cargaAC; s_cnz = cargaNZ; s_sel = selULA; s_h = halted;
    if (all_out != 13'd0) c_active++;
    if (s_inc) c_inc++;
    if (s_cac) c_ac++;
    if (s_wr)  c_wr++;
    if (s_cpc) c_pc++;
    if (s_rd)  c_read++;
    if (s_cac && s_sel == 3'd3) c_not++;
    if ((s_cnz != s_cac) || (!s_cac && s_sel != 3'd0) || (s_inc && s_cpc) ||
        (s_rd && s_wr) || (s_h && all_out[12:1] != 12'd0)) c_viol++;
    @(posedge ck);
    case (s_sel)
      3'd0:    u = ac + rdm;
      3'd1:    u = ac & rdm;
      3'd2:    u = ac | rdm;
      3'd3:    u = ~ac;
      3'd4:    u = rdm;
      default: u = 8'h00;
    endcase
    n_rem = s_crem ? (s_srem ? rdm : pc) : rem_r;
    n_rdm = (s_rd && memRdy) ? mem[rem_r] : rdm;
    n_pc  = s_cpc ? rdm : (s_inc ? pc + 8'd1 : pc);
    n_ri  = s_cri ? rdm : ri;
    n_ac  = s_cac ? u : ac;
    if (s_wr && memRdy) mem[rem_r] = ac;
    if (s_cnz) begin
      nf = u[7];
      zf = (u == 8'h00);
    end
    rem_r = n_rem; rdm = n_rdm; pc = n_pc; ri = n_ri; ac = n_ac;
    if (memRdy) in_acc = 1'b0;
    @(negedge ck);
    h = s_h;
  endtask

  task automatic run_until(input int budget, output int cyc);
    bit h;
    cyc = 0;
    h   = 1'b0;
    while (!h && cyc < budget) begin
      one_cycle(h);
      if (!h) cyc++;
    end
    check("halt_reached", int'(h), 1);
  endtask

  // Instruction-set level reference: cycles from the length rules plus memory waits.
  task automatic ref_run(output int e_cyc, output int e_inc, output logic [7:0] e_ac,
                         output logic [7:0] e_pc, output logic e_n, output logic e_z);
    logic [7:0] p, v;
    logic [3:0] o;
    int acc, steps;
    bit done;
    p = 8'h00; e_ac = ac; e_n = nf; e_z = zf;
    e_cyc = 0; e_inc = 0; acc = 0; steps = 0; done = 1'b0;
    while (!done && steps < 64) begin
      steps++;
      o = rm[p][7:4];
      p = p + 8'd1; e_inc++; acc++;
      case (o)
        4'h1: begin
          rm[rm[p]] = e_ac; p = p + 8'd1; e_inc++; acc += 2; e_cyc += 7;
        end
        4'h2, 4'h3, 4'h4, 4'h5: begin
          v = rm[rm[p]]; p = p + 8'd1; e_inc++; acc += 2; e_cyc += 8;
          if (o == 4'h2)      e_ac = v;
          else if (o == 4'h3) e_ac = e_ac + v;
          else if (o == 4'h4) e_ac = e_ac | v;
          else                e_ac = e_ac & v;
          e_n = e_ac[7]; e_z = (e_ac == 8'h00);
        end
        4'h6: begin
          e_ac = ~e_ac; e_n = e_ac[7]; e_z = (e_ac == 8'h00); e_cyc += 4;
        end
        4'h8: begin
          p = rm[p]; acc++; e_cyc += 6;
        end
        4'h9, 4'hA: begin
          if ((o == 4'h9) ? e_n : e_z) begin
            p = rm[p]; acc++; e_cyc += 6;
          end else begin
            p = p + 8'd1; e_inc++; e_cyc += 4;
          end
        end
        4'hF: begin
          e_cyc += 4; done = 1'b1;
        end
        default: e_cyc += 4;
      endcase
    end
    for (int k = 0; k < acc && k < 48; k++) e_cyc += lats[k];
    e_pc = p;
  endtask

  initial begin
    int cyc, cyc2, inc23, e_cyc, e_inc, diff, a;
    logic [7:0] e_ac, e_pc;
    logic e_n, e_z;
    bit h;
    int patch [$];

    nReset = 1'b0; run = 1'b0; step = 1'b0; memRdy = 1'b0;
    reset_env();
    clear_mem();
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};

    //            op    n     z     opnd   cyc inc ac wr pc  AC     m80    pc_final
    tv[0]  = '{4'h0, 1'b0, 1'b0, 8'hF0,  8, 2, 0, 0, 0, 8'h33, 8'h0F, 8'h02};
    tv[1]  = '{4'h1, 1'b0, 1'b0, 8'h80, 11, 3, 0, 1, 0, 8'h33, 8'h33, 8'h03};
    tv[2]  = '{4'h2, 1'b0, 1'b0, 8'h80, 12, 3, 1, 0, 0, 8'h0F, 8'h0F, 8'h03};
    tv[3]  = '{4'h3, 1'b0, 1'b0, 8'h80, 12, 3, 1, 0, 0, 8'h42, 8'h0F, 8'h03};
    tv[4]  = '{4'h4, 1'b0, 1'b0, 8'h80, 12, 3, 1, 0, 0, 8'h3F, 8'h0F, 8'h03};
    tv[5]  = '{4'h5, 1'b0, 1'b0, 8'h80, 12, 3, 1, 0, 0, 8'h03, 8'h0F, 8'h03};
    tv[6]  = '{4'h6, 1'b0, 1'b0, 8'hF0,  8, 2, 1, 0, 0, 8'hCC, 8'h0F, 8'h02};
    tv[7]  = '{4'h7, 1'b0, 1'b0, 8'hF0,  8, 2, 0, 0, 0, 8'h33, 8'h0F, 8'h02};
    tv[8]  = '{4'h8, 1'b0, 1'b0, 8'h10, 10, 2, 0, 0, 1, 8'h33, 8'h0F, 8'h11};
    tv[9]  = '{4'h9, 1'b0, 1'b0, 8'h10,  8, 3, 0, 0, 0, 8'h33, 8'h0F, 8'h03};
    tv[10] = '{4'h9, 1'b1, 1'b0, 8'h10, 10, 2, 0, 0, 1, 8'h33, 8'h0F, 8'h11};
    tv[11] = '{4'hA, 1'b0, 1'b0, 8'h10,  8, 3, 0, 0, 0, 8'h33, 8'h0F, 8'h03};
    tv[12] = '{4'hA, 1'b0, 1'b1, 8'h10, 10, 2, 0, 0, 1, 8'h33, 8'h0F, 8'h11};
    tv[13] = '{4'hB, 1'b0, 1'b0, 8'hF0,  8, 2, 0, 0, 0, 8'h33, 8'h0F, 8'h02};
    tv[14] = '{4'hE, 1'b0, 1'b0, 8'hF0,  8, 2, 0, 0, 0, 8'h33, 8'h0F, 8'h02};
    tv[15] = '{4'hF, 1'b0, 1'b0, 8'hF0,  4, 1, 0, 0, 0, 8'h33, 8'h0F, 8'h01};

    // Reset state
    @(negedge ck); @(negedge ck);
    #1;
    check("reset_outputs", int'(all_out), 0);

    // Single-instruction table with zero-wait memory
    for (int i = 0; i < 16; i++) begin
      do_reset();
      clear_mem();
      mem[0] = {tv[i].op, 4'h0}; mem[1] = tv[i].opnd; mem[2] = 8'hF0;
      mem[8'h10] = 8'hF0; mem[8'h80] = 8'h0F;
      ac = 8'h33; nf = tv[i].n; zf = tv[i].z;
      run = 1'b1;
      @(negedge ck);
      run_until(100, cyc);
      check($sformatf("v%0d_cycles", i), cyc, tv[i].cyc);
      check($sformatf("v%0d_incPC", i), c_inc, tv[i].inc);
      check($sformatf("v%0d_cargaAC", i), c_ac, tv[i].nac);
      check($sformatf("v%0d_write", i), c_wr, tv[i].nwr);
      check($sformatf("v%0d_cargaPC", i), c_pc, tv[i].npc);
      check($sformatf("v%0d_ac", i), int'(ac), int'(tv[i].ac));
      check($sformatf("v%0d_m80", i), int'(mem[8'h80]), int'(tv[i].m80));
      check($sformatf("v%0d_pc", i), int'(pc), int'(tv[i].pcf));
      check($sformatf("v%0d_protocol", i), c_viol, 0);
    end

    // Asynchronous reset in T4 of LDA, then restart
    do_reset();
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h80; mem[2] = 8'hF0; mem[8'h80] = 8'h5A;
    run = 1'b1;
    @(negedge ck);
    for (int k = 0; k < 4; k++) one_cycle(h);
    check("t4_read", int'(read), 1);
    #2 nReset = 1'b0;
    #1 check("async_reset_outputs", int'(all_out), 0);
    @(negedge ck);
    reset_env();
    memRdy = 1'b0;
    @(negedge ck);
    nReset = 1'b1;
    @(negedge ck);
    #1 check("restart_t0", int'({cargaREM, selREM, read}), 4);
    run_until(60, cyc);
    check("restart_cycles", cyc, 12);
    check("restart_ac", int'(ac), 8'h5A);

    // LDA 80; ADD 81; STA 82; HLT
    do_reset();
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h80; mem[2] = 8'h30; mem[3] = 8'h81;
    mem[4] = 8'h10; mem[5] = 8'h82; mem[6] = 8'hF0;
    mem[8'h80] = 8'h05; mem[8'h81] = 8'hFB; mem[8'h82] = 8'h77;
    run = 1'b1;
    @(negedge ck);
    for (int k = 0; k < 23; k++) one_cycle(h);
    inc23 = c_inc;
    run_until(20, cyc2);
    check("prog_cycles", 23 + cyc2, 27);
    check("prog_incPC_3instr", inc23, 6);
    check("prog_m82", int'(mem[8'h82]), 0);
    check("prog_zn", int'({zf, nf}), 2);
    check("prog_pc", int'(pc), 7);

    // Fetch with memRdy low for 3 cycles
    do_reset();
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'hF0;
    lat_q.push_back(3);
    run = 1'b1;
    @(negedge ck);
    run_until(40, cyc);
    check("wait_cycles", cyc, 11);
    check("wait_read", c_read, 5);
    check("wait_incPC", c_inc, 2);

    // Step pulse on NOT with run low
    do_reset();
    clear_mem();
    mem[0] = 8'h60; mem[1] = 8'hF0;
    ac = 8'h0F;
    step = 1'b1;
    one_cycle(h);
    step = 1'b0;
    for (int k = 0; k < 14; k++) one_cycle(h);
`ifdef NEANDER_SINGLE_STEP_EN
    check("step_active", c_active, 4);
    check("step_not_sel", c_not, 1);
    check("step_ac", int'(ac), 8'hF0);
`else
    check("step_active", c_active, 0);
    check("step_not_sel", c_not, 0);
    check("step_ac", int'(ac), 8'h0F);
`endif

    // Random programs against the instruction-level reference
    for (int t = 0; t < 6; t++) begin
      do_reset();
      clear_mem();
      patch.delete();
      a = 0;
      for (int i = 0; i < 10; i++) begin
        logic [3:0] op;
        op = ops[$urandom_range(0, 11)];
        mem[a] = {op, 4'h0};
        a++;
        if (op >= 4'h1 && op <= 4'h5) begin
          mem[a] = 8'h80 + 8'($urandom_range(0, 7));
          a++;
        end else if (op >= 4'h8 && op <= 4'hA) begin
          if ($urandom_range(0, 1) == 1) mem[a] = 8'(a + 1);
          else patch.push_back(a);
          a++;
        end
      end
      mem[a] = 8'hF0;
      foreach (patch[k]) mem[patch[k]] = 8'(a);
      for (int k = 0; k < 8; k++) mem[8'h80 + k] = 8'($urandom);
      ac = 8'($urandom); nf = 1'($urandom); zf = 1'($urandom);
      for (int k = 0; k < 48; k++) begin
        lats[k] = $urandom_range(0, 2);
        lat_q.push_back(lats[k]);
      end
      for (int k = 0; k < 256; k++) rm[k] = mem[k];
      ref_run(e_cyc, e_inc, e_ac, e_pc, e_n, e_z);
      run = 1'b1;
      @(negedge ck);
      run_until(1000, cyc);
      diff = 0;
      for (int k = 0; k < 8; k++) if (mem[8'h80 + k] != rm[8'h80 + k]) diff++;
      check($sformatf("r%0d_cycles", t), cyc, e_cyc);
      check($sformatf("r%0d_incPC", t), c_inc, e_inc);
      check($sformatf("r%0d_ac", t), int'(ac), int'(e_ac));
      check($sformatf("r%0d_pc", t), int'(pc), int'(e_pc));
      check($sformatf("r%0d_nz", t), int'({nf, zf}), int'({e_n, e_z}));
      check($sformatf("r%0d_mem", t), diff, 0);
      check($sformatf("r%0d_protocol", t), c_viol, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
